// File: rtl/s_port_pkg.sv
// Shared definitions for the serial-bus target port: default widths, phase encodings and FSM states.
package s_port_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  localparam logic BUS_MODE_ADDR = 1'b0;
  localparam logic BUS_MODE_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WDATA  = 3'd2,
    ST_REQ    = 3'd3,
    ST_RFETCH = 3'd4,
    ST_RSEND  = 3'd5,
    ST_ACK    = 3'd6
  } s_port_state_t;

endpackage

// File: rtl/s_port_if.sv
// Serial-bus side plus parallel slave side of the target port, bundled for port hookup.
interface s_port_if
  import s_port_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              bus_data_in;
  logic              bus_data_in_valid;
  logic              bus_mode;
  logic              bus_m_rw;
  logic              bus_m_ready;
  logic              bus_data_out;
  logic              bus_data_out_valid;
  logic              s_ack;
  logic              s_split;
  logic [ADDR_W-1:0] s_address_out;
  logic              s_address_out_valid;
  logic              s_rw;
  logic [DATA_W-1:0] s_data_out;
  logic              s_data_out_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data_in;
  logic              s_data_in_valid;

  // Target-port view
  modport slave (
    input  bus_data_in, bus_data_in_valid, bus_mode, bus_m_rw, bus_m_ready,
    input  s_ready, s_data_in, s_data_in_valid,
    output bus_data_out, bus_data_out_valid, s_ack, s_split,
    output s_address_out, s_address_out_valid, s_rw, s_data_out, s_data_out_valid
  );

  // Initiator plus attached-slave view
  modport master (
    output bus_data_in, bus_data_in_valid, bus_mode, bus_m_rw, bus_m_ready,
    output s_ready, s_data_in, s_data_in_valid,
    input  bus_data_out, bus_data_out_valid, s_ack, s_split,
    input  s_address_out, s_address_out_valid, s_rw, s_data_out, s_data_out_valid
  );

endinterface

// File: rtl/s_port_piso_shift.sv
// Parallel-in serial-out shifter for read data; LSB presented first, o_last_c flags the final bit.
module piso_shift #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift_en,
  output logic              o_bit,
  output logic              o_last_c
);

  localparam int unsigned IDX_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);

  logic [DATA_W-1:0] r_sr;
  logic [IDX_W-1:0]  r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_idx <= '0;
    end else if (i_shift_en) begin
      r_sr  <= {1'b0, r_sr[DATA_W-1:1]};
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_bit    = r_sr[0];
  assign o_last_c = (r_idx == IDX_W'(DATA_W - 1));

endmodule

// File: rtl/s_port.sv
// Serial-bus target port: deserialises address/write data, issues a parallel slave request,
// and serialises fetched read data back to the initiator.
module s_port
  import s_port_pkg::*;
#(
  parameter int unsigned         ADDR_W        = ADDR_W_DEF,
  parameter int unsigned         DATA_W        = DATA_W_DEF,
  parameter int unsigned         DEV_ID_W      = 4,
  parameter logic [DEV_ID_W-1:0] DEV_ID        = DEV_ID_W'(1),
  parameter int unsigned         SPLIT_TIMEOUT = 8
) (
  input logic     clk,
  input logic     rst_n,
  s_port_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(ADDR_W + 1);
  localparam int unsigned AIDX_W = $clog2(ADDR_W);
  localparam int unsigned DIDX_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam int unsigned TMO_W  = (SPLIT_TIMEOUT < 2) ? 1 : $clog2(SPLIT_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(SPLIT_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((SPLIT_TIMEOUT == 0) ? 0 : SPLIT_TIMEOUT - 1);

  s_port_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_rw;
  logic              r_drain;
  logic              r_addr_valid;
  logic              r_data_valid;
  logic              r_ack;
  logic              r_split;
  logic              r_split_done;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_sending;

  logic [ADDR_W-1:0] w_addr_full;
  logic              w_id_match;
  logic              w_piso_load;
  logic              w_piso_shift;
  logic              w_piso_bit;
  logic              w_piso_last;

  // Decode uses the bit arriving now as the address MSB
  assign w_addr_full  = {bus.bus_data_in, r_addr[ADDR_W-2:0]};
  assign w_id_match   = (w_addr_full[ADDR_W-1 -: DEV_ID_W] == DEV_ID);
  assign w_piso_load  = (r_state == ST_RFETCH) && bus.s_data_in_valid;
  assign w_piso_shift = r_sending && bus.bus_m_ready;

  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_piso_load),
    .i_data     (bus.s_data_in),
    .i_shift_en (w_piso_shift),
    .o_bit      (w_piso_bit),
    .o_last_c   (w_piso_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rw         <= 1'b0;
      r_drain      <= 1'b0;
      r_addr_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_split      <= 1'b0;
      r_split_done <= 1'b0;
      r_tmo        <= '0;
      r_sending    <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_split <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // After a foreign-ID address, swallow the rest of that burst until the bus goes quiet
          if (r_drain) begin
            if (!bus.bus_data_in_valid) r_drain <= 1'b0;
          end else if (bus.bus_data_in_valid && (bus.bus_mode == BUS_MODE_ADDR)) begin
            r_addr[0] <= bus.bus_data_in;
            r_rw      <= bus.bus_m_rw;
            r_cnt     <= CNT_W'(1);
            r_state   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (bus.bus_data_in_valid) begin
            r_addr[r_cnt[AIDX_W-1:0]] <= bus.bus_data_in;
            if (r_cnt == ADDR_LAST) begin
              r_cnt <= '0;
              if (!w_id_match) begin
                r_drain <= 1'b1;
                r_state <= ST_IDLE;
              end else if (r_rw) begin
                r_state <= ST_WDATA;
              end else begin
                r_addr_valid <= 1'b1;
                r_state      <= ST_REQ;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        ST_WDATA: begin
          if (bus.bus_data_in_valid) begin
            if (bus.bus_mode == BUS_MODE_DATA) begin
              r_data[r_cnt[DIDX_W-1:0]] <= bus.bus_data_in;
              if (r_cnt == DATA_LAST) begin
                r_cnt        <= '0;
                r_addr_valid <= 1'b1;
                r_data_valid <= 1'b1;
                r_state      <= ST_REQ;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_REQ: begin
          if (bus.s_ready) begin
            r_addr_valid <= 1'b0;
            r_data_valid <= 1'b0;
            if (r_rw) begin
              r_ack   <= 1'b1;
              r_state <= ST_ACK;
            end else begin
              r_tmo        <= '0;
              r_split_done <= 1'b0;
              r_state      <= ST_RFETCH;
            end
          end
        end

        ST_RFETCH: begin
          // Returned data takes priority over a coincident timeout
          if (bus.s_data_in_valid) begin
            r_sending <= 1'b1;
            r_state   <= ST_RSEND;
          end else begin
            if (r_tmo != TMO_MAX) r_tmo <= r_tmo + TMO_W'(1);
            if ((SPLIT_TIMEOUT != 0) && !r_split_done && (r_tmo == TMO_LAST)) begin
              r_split      <= 1'b1;
              r_split_done <= 1'b1;
            end
          end
        end

        ST_RSEND: begin
          if (bus.bus_m_ready && w_piso_last) begin
            r_sending <= 1'b0;
            r_ack     <= 1'b1;
            r_state   <= ST_ACK;
          end
        end

        ST_ACK: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-bit valid follows the initiator's ready within the cycle so a stalled bit is never lost
  assign bus.bus_data_out        = w_piso_bit;
  assign bus.bus_data_out_valid  = r_sending & bus.bus_m_ready;
  assign bus.s_ack               = r_ack;
  assign bus.s_split             = r_split;
  assign bus.s_address_out       = r_addr;
  assign bus.s_address_out_valid = r_addr_valid;
  assign bus.s_rw                = r_rw;
  assign bus.s_data_out          = r_data;
  assign bus.s_data_out_valid    = r_data_valid;

endmodule

// File: tb/tb_s_port.sv
// Scoreboard bench for s_port: stimulus queues expected requests/read bytes/acks, a negedge monitor checks them.
module tb_s_port;
  import s_port_pkg::*;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  s_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  s_port #(
    .ADDR_W(AW), .DATA_W(DW), .DEV_ID_W(4), .DEV_ID(4'h1), .SPLIT_TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [15:0] addr; logic rw; logic [7:0] data; } req_t;
  typedef struct { logic [7:0] data; int span; } rbyte_t;
  typedef struct { logic wr; int cyc; int splits; } ack_t;

  req_t   exp_req[$];
  rbyte_t exp_rb[$];
  ack_t   exp_ack[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model configuration (written by stimulus only)
  int         stall_cfg = 0;
  int         rd_delay  = 2;
  logic [7:0] rd_byte   = 8'h00;

  // monitor state (written by monitor only)
  int         mon_bits = 0;
  logic [7:0] mon_byte = 8'h00;
  int         first_cyc = 0, last_bit_cyc = 0, acc_cyc = 0, split_cyc = 0, split_cnt = 0;
  int         acks_seen = 0;

  int n_acks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected DUT output at cycle %0d", name, cyc);
  endfunction

  // Attached slave: optional ready stall per request, read data returned rd_delay cycles after acceptance
  initial begin
    int  stall_left;
    bit  pend;
    bit  seen;
    int  wait_n;
    stall_left = 0; pend = 0; seen = 0; wait_n = 0;
    bus.s_ready = 1'b1;
    bus.s_data_in = '0;
    bus.s_data_in_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin pend = 0; seen = 0; end
      bus.s_data_in_valid = 1'b0;
      bus.s_data_in = '0;
      if (pend) begin
        wait_n--;
        if (wait_n == 0) begin
          bus.s_data_in_valid = 1'b1;
          bus.s_data_in = rd_byte;
          pend = 0;
        end
      end
      if (bus.s_address_out_valid && !seen) begin
        seen = 1;
        stall_left = stall_cfg;
      end
      if (bus.s_address_out_valid && stall_left > 0) begin
        bus.s_ready = 1'b0;
        stall_left--;
      end else begin
        bus.s_ready = 1'b1;
      end
      @(negedge clk);
      if (rst_n && bus.s_address_out_valid && bus.s_ready) begin
        seen = 0;
        if (!bus.s_rw) begin
          pend = 1;
          wait_n = rd_delay;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    req_t   r;
    rbyte_t b;
    ack_t   a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_req.delete(); exp_rb.delete(); exp_ack.delete();
        mon_bits = 0; split_cnt = 0;
      end else begin
        if (bus.s_address_out_valid && bus.s_ready) begin
          if (exp_req.size() == 0) flag("unexpected_request");
          else begin
            r = exp_req.pop_front();
            check("req_addr", 32'(bus.s_address_out), 32'(r.addr));
            check("req_rw", 32'(bus.s_rw), 32'(r.rw));
            check("req_data_valid", 32'(bus.s_data_out_valid), 32'(r.rw));
            if (r.rw) check("req_wdata", 32'(bus.s_data_out), 32'(r.data));
          end
          acc_cyc = cyc;
        end
        if (bus.s_split) begin
          split_cnt++;
          split_cyc = cyc;
        end
        if (bus.bus_data_out_valid) begin
          if (mon_bits == 0) first_cyc = cyc;
          mon_byte[mon_bits] = bus.bus_data_out;
          mon_bits++;
          if (mon_bits == 8) begin
            mon_bits = 0;
            last_bit_cyc = cyc;
            if (exp_rb.size() == 0) flag("unexpected_read_byte");
            else begin
              b = exp_rb.pop_front();
              check("read_byte", 32'(mon_byte), 32'(b.data));
              check("read_span", 32'(cyc - first_cyc), 32'(b.span));
            end
          end
        end
        if (bus.s_ack) begin
          acks_seen++;
          if (exp_ack.size() == 0) flag("unexpected_ack");
          else begin
            a = exp_ack.pop_front();
            if (a.wr) check("wr_ack_cycle", 32'(cyc), 32'(a.cyc));
            else      check("rd_ack_cycle", 32'(cyc), 32'(last_bit_cyc + 1));
            check("split_count", 32'(split_cnt), 32'(a.splits));
            // split rises TMO clocks after the fetch starts (acceptance cycle + TMO + 1)
            if (a.splits == 1) check("split_cycle", 32'(split_cyc - acc_cyc), 32'(TMO + 1));
          end
          split_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.bus_data_in_valid = 1'b0;
      bus.bus_data_in = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input logic mode, input logic rw);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.bus_data_in_valid = 1'b1;
      bus.bus_mode = mode;
      bus.bus_m_rw = rw;
      bus.bus_data_in = v[i];
    end
  endtask

  task automatic wait_ack(input int target);
    for (int i = 0; i < 300 && acks_seen < target; i++) tick();
    check("ack_arrived", 32'(acks_seen >= target), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 300 && mon_bits < n; i++) tick();
    check("read_bits_started", 32'(mon_bits >= n), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_strobes"}, {26'b0, bus.bus_data_out_valid, bus.s_ack, bus.s_split,
                              bus.s_address_out_valid, bus.s_data_out_valid, bus.s_rw}, 32'd0);
    check({tag, "_buses"}, {7'b0, bus.bus_data_out, bus.s_data_out, bus.s_address_out}, 32'd0);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int stall);
    stall_cfg = stall;
    exp_req.push_back('{addr: addr, rw: 1'b1, data: data});
    send_bits(addr, 16, BUS_MODE_ADDR, 1'b1);
    send_bits({8'h00, data}, 8, BUS_MODE_DATA, 1'b1);
    exp_ack.push_back('{wr: 1'b1, cyc: cyc + 2 + stall, splits: 0});
    idle(1);
    n_acks++;
    wait_ack(n_acks);
    idle(2);
    stall_cfg = 0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] data, input int delay,
                         input int splits, input int span, input bit gap);
    rd_byte = data;
    rd_delay = delay;
    exp_req.push_back('{addr: addr, rw: 1'b0, data: 8'h00});
    exp_rb.push_back('{data: data, span: span});
    exp_ack.push_back('{wr: 1'b0, cyc: 0, splits: splits});
    send_bits(addr, 16, BUS_MODE_ADDR, 1'b0);
    idle(1);
    if (gap) begin
      wait_bits(4);
      bus.bus_m_ready = 1'b0;
      tick(); tick(); tick();
      bus.bus_m_ready = 1'b1;
    end
    n_acks++;
    wait_ack(n_acks);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_data_in = 1'b0;
    bus.bus_data_in_valid = 1'b0;
    bus.bus_mode = BUS_MODE_ADDR;
    bus.bus_m_rw = 1'b0;
    bus.bus_m_ready = 1'b1;

    tick(); tick(); tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);
    check_outputs_zero("post_reset");

    do_write(16'h1234, 8'h3C, 0);
    do_read(16'h1357, 8'h96, 2, 0, 7, 1'b0);
    do_read(16'h1ACE, 8'h5A, 12, 1, 7, 1'b0);
    do_read(16'h1357, 8'h96, 2, 0, 10, 1'b1);
    do_read(16'h1246, 8'hC3, 8, 0, 7, 1'b0);

    // foreign ID: no request, no ack
    send_bits(16'h9ACE, 16, BUS_MODE_ADDR, 1'b1);
    send_bits(16'h0055, 8, BUS_MODE_DATA, 1'b1);
    idle(6);
    check("mismatch_no_ack", 32'(acks_seen), 32'(n_acks));
    do_write(16'h1000, 8'hA5, 0);

    // address-phase bit during write data aborts the transaction
    send_bits(16'h1234, 16, BUS_MODE_ADDR, 1'b1);
    send_bits(16'h0005, 4, BUS_MODE_DATA, 1'b1);
    send_bits(16'h0000, 1, BUS_MODE_ADDR, 1'b1);
    idle(6);
    check("proto_err_no_ack", 32'(acks_seen), 32'(n_acks));
    do_write(16'h1FFF, 8'hFF, 2);

    // reset while bit 4 of a read is on the bus
    rd_byte = 8'h96;
    rd_delay = 2;
    exp_req.push_back('{addr: 16'h1357, rw: 1'b0, data: 8'h00});
    send_bits(16'h1357, 16, BUS_MODE_ADDR, 1'b0);
    idle(1);
    wait_bits(4);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_rsend_reset");
    tick(); tick();
    rst_n = 1'b1;
    idle(2);
    check_outputs_zero("after_abort");
    do_read(16'h1357, 8'h96, 2, 0, 7, 1'b0);

    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("rbyte_queue_empty", 32'(exp_rb.size()), 32'd0);
    check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
